adpcm_rom_arbiter: RTL and testbench

// - Shares the single ADPCM sample-ROM read port between the six ADPCM-A channels (req 0..5) and the ADPCM-B channel (req 6).
// - Each channel raises a request with a 22-bit ROM address.
// - The arbiter selects one requester, drives the ROM bus, waits the ROM access time, latches the byte and acks the winner.
// - Sits between the ch_pcma/ch_pcmb instances and the V-ROM bus inside the YM2610 audio block.

---
 rtl/adpcm_rom_arbiter_if.sv | 25 ++
 rtl/adpcm_rom_arbiter.sv | 138 +++++++++++++
 tb/tb_adpcm_rom_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/adpcm_rom_arbiter_if.sv
// Channel-side request/ack signals and V-ROM bus for the ADPCM sample-ROM arbiter.
// The arbiter connects through the slave modport; the channels and ROM connect through master.
interface adpcm_rom_arbiter_if #(
    parameter int NREQ   = 7,
    parameter int ADDR_W = 22
);
    logic [NREQ-1:0]        REQ;
    logic [NREQ*ADDR_W-1:0] ADDR_IN;
    logic [NREQ-1:0]        ACK;
    logic [7:0]             RD_DATA;
    logic [ADDR_W-1:0]      ROM_ADDR;
    logic [7:0]             ROM_DATA;
    logic                   nROE;
    logic                   BUSY;

    modport master (
        output REQ, ADDR_IN, ROM_DATA,
        input  ACK, RD_DATA, ROM_ADDR, nROE, BUSY
    );

    modport slave (
        input  REQ, ADDR_IN, ROM_DATA,
        output ACK, RD_DATA, ROM_ADDR, nROE, BUSY
    );
endinterface

// File: rtl/adpcm_rom_arbiter.sv
// Round-robin arbiter sharing the V-ROM read port between six ADPCM-A channels and ADPCM-B.
// Optional macro PCMB_PRIORITY_EN gives ADPCM-B (index NREQ-1) absolute priority.
module adpcm_rom_arbiter #(
    parameter int NREQ     = 7,
    parameter int ADDR_W   = 22,
    parameter int ROM_WAIT = 4
) (
    input  logic               CLK,
    input  logic               nRESET,
    adpcm_rom_arbiter_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic [IDX_W-1:0]    last, last_nxt;
    logic [IDX_W-1:0]    win, win_nxt;
    logic [IDX_W-1:0]    pick;
    logic [IDX_W-1:0]    rr_idx;
    logic                pick_vld;
    logic [NREQ-1:0]     rr_req;
    logic [NREQ-1:0]     ack, ack_nxt;
    logic [7:0]          rd_data, rd_data_nxt;
    logic [ADDR_W-1:0]   rom_addr, rom_addr_nxt;
    logic                nroe, nroe_nxt;
    logic                busy, busy_nxt;
    logic [ADDR_W-1:0]   addr_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_addr
        assign addr_arr[g] = bus.ADDR_IN[g*ADDR_W +: ADDR_W];
    end

`ifdef PCMB_PRIORITY_EN
    // ADPCM-B is taken out of the rotation; it is handled as an override below.
    assign rr_req = {1'b0, bus.REQ[NREQ-2:0]};
`else
    assign rr_req = bus.REQ;
`endif

    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            rr_idx = IDX_W'((int'(last) + 1 + k) % NREQ);
            if (!pick_vld && rr_req[rr_idx]) begin
                pick_vld = 1'b1;
                pick     = rr_idx;
            end
        end
`ifdef PCMB_PRIORITY_EN
        if (bus.REQ[NREQ-1]) begin
            pick_vld = 1'b1;
            pick     = IDX_W'(NREQ-1);
        end
`endif
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        last_nxt     = last;
        win_nxt      = win;
        ack_nxt      = ack;
        rd_data_nxt  = rd_data;
        rom_addr_nxt = rom_addr;
        nroe_nxt     = nroe;
        busy_nxt     = busy;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    win_nxt      = pick;
                    rom_addr_nxt = addr_arr[pick];
                    nroe_nxt     = 1'b0;
                    busy_nxt     = 1'b1;
                    cnt_nxt      = 4'(ROM_WAIT - 1);
                    state_nxt    = WAIT;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    // A withdrawn request still completes the access; only the ACK is dropped.
                    rd_data_nxt  = bus.ROM_DATA;
                    nroe_nxt     = 1'b1;
                    ack_nxt      = '0;
                    ack_nxt[win] = bus.REQ[win];
`ifdef PCMB_PRIORITY_EN
                    if (win != IDX_W'(NREQ-1))
                        last_nxt = win;
`else
                    last_nxt     = win;
`endif
                    state_nxt    = DONE;
                end
            end
            DONE: begin
                ack_nxt   = '0;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            last     <= IDX_W'(NREQ-1);
            win      <= '0;
            ack      <= '0;
            rd_data  <= 8'd0;
            rom_addr <= '0;
            nroe     <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last     <= last_nxt;
            win      <= win_nxt;
            ack      <= ack_nxt;
            rd_data  <= rd_data_nxt;
            rom_addr <= rom_addr_nxt;
            nroe     <= nroe_nxt;
            busy     <= busy_nxt;
        end
    end

    assign bus.ACK      = ack;
    assign bus.RD_DATA  = rd_data;
    assign bus.ROM_ADDR = rom_addr;
    assign bus.nROE     = nroe;
    assign bus.BUSY     = busy;
endmodule

// File: tb/tb_adpcm_rom_arbiter.sv
// Directed bench for adpcm_rom_arbiter: reset, single access timing, round-robin order,
// withdrawn request, mid-access reset, address latching and (if PCMB_PRIORITY_EN) B priority.
module tb_adpcm_rom_arbiter;
    localparam int NREQ     = 7;
    localparam int ADDR_W   = 22;
    localparam int ROM_WAIT = 4;

    logic              CLK = 1'b0;
    logic              nRESET;
    logic [7:0]        rom_byte;
    logic [ADDR_W-1:0] addr_tab [NREQ];
    int                n_checks = 0;
    int                n_pass   = 0;

    adpcm_rom_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W)) rom_if();

    adpcm_rom_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .ROM_WAIT(ROM_WAIT)) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (rom_if)
    );

    always #5 CLK = ~CLK;

    assign rom_if.ROM_DATA = rom_byte;

    always_comb begin
        rom_if.ADDR_IN = '0;
        for (int i = 0; i < NREQ; i++)
            rom_if.ADDR_IN[i*ADDR_W +: ADDR_W] = addr_tab[i];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rom_if.REQ = '0;
        nRESET = 1'b0;
        tick(1);
        nRESET = 1'b1;
    endtask

    task automatic wait_ack(input string tag, output logic [NREQ-1:0] a);
        a = '0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (rom_if.ACK != '0) begin
                a = rom_if.ACK;
                break;
            end
        end
        if (a == '0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        logic [NREQ-1:0] a;
        int exp_idx;
        int last_c;

        rom_if.REQ = '0;
        rom_byte   = 8'h00;
        nRESET     = 1'b0;
        for (int i = 0; i < NREQ; i++)
            addr_tab[i] = ADDR_W'(32'h000200 + i * 32'h011111);

        // reset values
        tick(2);
        check("rst_ack",   32'(rom_if.ACK),      32'h0);
        check("rst_rdata", 32'(rom_if.RD_DATA),  32'h0);
        check("rst_addr",  32'(rom_if.ROM_ADDR), 32'h0);
        check("rst_nroe",  32'(rom_if.nROE),     32'h1);
        check("rst_busy",  32'(rom_if.BUSY),     32'h0);
        nRESET = 1'b1;

        // single access, channel 0
        addr_tab[0] = 22'h012345;
        rom_byte    = 8'hA5;
        rom_if.REQ  = 7'b0000001;
        tick(1);
        check("t1_addr", 32'(rom_if.ROM_ADDR), 32'h012345);
        check("t1_nroe", 32'(rom_if.nROE),     32'h0);
        check("t1_busy", 32'(rom_if.BUSY),     32'h1);
        for (int k = 1; k < ROM_WAIT; k++) begin
            tick(1);
            check("t1_early_ack", 32'(rom_if.ACK), 32'h0);
        end
        tick(1);
        check("t1_ack",   32'(rom_if.ACK),     32'h01);
        check("t1_rdata", 32'(rom_if.RD_DATA), 32'hA5);
        check("t1_nroe2", 32'(rom_if.nROE),    32'h1);
        rom_if.REQ = '0;
        tick(1);
        check("t1_ack_off", 32'(rom_if.ACK),  32'h0);
        check("t1_busy_off", 32'(rom_if.BUSY), 32'h0);

        // round-robin over all requesters
        do_reset();
        addr_tab[0] = 22'h000200;
        rom_byte    = 8'h11;
        rom_if.REQ  = 7'h7F;
        exp_idx = 0;
        last_c  = -1;
        for (int c = 0; c < 80 && exp_idx < NREQ; c++) begin
            tick(1);
            if (rom_if.ACK != '0) begin
                check("rr_ack",  32'(rom_if.ACK),      32'(7'b1 << exp_idx));
                check("rr_addr", 32'(rom_if.ROM_ADDR), 32'(addr_tab[exp_idx]));
                if (last_c >= 0) check("rr_period", 32'(c - last_c), 32'd6);
                last_c = c;
                rom_if.REQ = rom_if.REQ & ~rom_if.ACK;
                exp_idx++;
            end
        end
        check("rr_count", 32'(exp_idx), 32'd7);

        // request withdrawn mid-access
        do_reset();
        rom_byte   = 8'h3C;
        rom_if.REQ = 7'b0001000;
        tick(1);
        check("wd_addr", 32'(rom_if.ROM_ADDR), 32'(addr_tab[3]));
        check("wd_nroe", 32'(rom_if.nROE),     32'h0);
        tick(2);
        rom_if.REQ = 7'b0100001;
        tick(1);
        check("wd_nroe_mid", 32'(rom_if.nROE), 32'h0);
        tick(1);
        check("wd_no_ack", 32'(rom_if.ACK),     32'h0);
        check("wd_nroe_hi", 32'(rom_if.nROE),   32'h1);
        check("wd_rdata",  32'(rom_if.RD_DATA), 32'h3C);
        tick(1);
        check("wd_busy_off", 32'(rom_if.BUSY), 32'h0);
        tick(1);
        check("wd_next_addr", 32'(rom_if.ROM_ADDR), 32'(addr_tab[5]));
        tick(ROM_WAIT);
        check("wd_next_ack", 32'(rom_if.ACK), 32'h20);
        rom_if.REQ = '0;
        tick(1);

        // reset during WAIT
        do_reset();
        rom_byte   = 8'h77;
        rom_if.REQ = 7'b0000001;
        tick(3);
        nRESET = 1'b0;
        #1;
        check("ar_nroe", 32'(rom_if.nROE), 32'h1);
        check("ar_busy", 32'(rom_if.BUSY), 32'h0);
        check("ar_ack",  32'(rom_if.ACK),  32'h0);
        rom_if.REQ = 7'b1000001;
        tick(1);
        nRESET = 1'b1;
        tick(1);
        check("ar_grant_addr", 32'(rom_if.ROM_ADDR), 32'(addr_tab[0]));
        check("ar_grant_nroe", 32'(rom_if.nROE),     32'h0);
        tick(ROM_WAIT);
        check("ar_grant_ack", 32'(rom_if.ACK),     32'h01);
        check("ar_rdata",     32'(rom_if.RD_DATA), 32'h77);
        rom_if.REQ = '0;
        tick(1);

        // address latched at grant
        do_reset();
        addr_tab[1] = 22'h000100;
        rom_if.REQ  = 7'b0000010;
        tick(1);
        check("al_addr", 32'(rom_if.ROM_ADDR), 32'h000100);
        tick(1);
        addr_tab[1] = 22'h3FFFFF;
        tick(ROM_WAIT - 1);
        check("al_ack",  32'(rom_if.ACK),      32'h02);
        check("al_hold", 32'(rom_if.ROM_ADDR), 32'h000100);
        rom_if.REQ = '0;
        tick(2);
        check("al_idle_addr", 32'(rom_if.ROM_ADDR), 32'h000100);
        check("al_idle_nroe", 32'(rom_if.nROE),     32'h1);

`ifdef PCMB_PRIORITY_EN
        // ADPCM-B priority
        do_reset();
        rom_if.REQ = 7'b1000100;
        for (int n = 0; n < 3; n++) begin
            wait_ack("pr_b", a);
            check("pr_b_ack", 32'(a), 32'h40);
        end
        rom_if.REQ = 7'b0000100;
        wait_ack("pr_a", a);
        check("pr_a_ack", 32'(a), 32'h04);
        rom_if.REQ = '0;
        tick(1);
`else
        // plain round-robin: from reset, 2 is found before 6, then 6
        do_reset();
        rom_if.REQ = 7'b1000100;
        wait_ack("rr2", a);
        check("rr2_first", 32'(a), 32'h04);
        rom_if.REQ = 7'b1000000;
        wait_ack("rr6", a);
        check("rr6_second", 32'(a), 32'h40);
        rom_if.REQ = '0;
        tick(1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
